// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants, byte-count/address types and helpers for
//                the fetch byte queue and its byte aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int LINE_BYTES = 16;   // I-cache line size in bytes
    localparam int QBYTES_DEF = 32;   // default queue capacity in bytes
    localparam int IADDRW_DEF = 32;   // default address width

    // Byte counts span 0..63, which covers every legal queue depth.
    typedef logic [5:0]            bcnt_t;
    typedef logic [IADDRW_DEF-1:0] addr_t;

    // Decode never sees more than one line's worth of bytes at a time.
    function automatic bcnt_t clamp16(input bcnt_t c);
        return (c > bcnt_t'(LINE_BYTES)) ? bcnt_t'(LINE_BYTES) : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_byte_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_byte_queue_if
//  Description : I-cache line request and decode byte-stream handshakes of
//                the fetch byte queue.
//                master : the queue (issues ic_addr, presents decode bytes)
//                slave  : the I-cache / decode environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_byte_queue_if #(
    parameter int IADDRW = 32
);
    // I-cache side
    logic [IADDRW-1:0] ic_addr;
    logic              ic_valid;
    logic              ic_ready;
    logic [127:0]      ic_line;
    // Decode side
    logic              f_valid;
    logic              f_ready;
    logic [5:0]        f_bytes_read;
    logic [5:0]        f_valid_bytes;
    logic [127:0]      f_instruction;
    logic [IADDRW-1:0] f_pc;
    logic              f_branch_taken;

    modport master (
        output ic_addr, ic_ready,
        output f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken,
        input  ic_valid, ic_line,
        input  f_ready, f_bytes_read
    );

    modport slave (
        input  ic_addr, ic_ready,
        input  f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken,
        output ic_valid, ic_line,
        output f_ready, f_bytes_read
    );
endinterface
`default_nettype wire

// File: rtl/fbq_byte_align.sv
`default_nettype none
// ============================================================================
//  Module      : fbq_byte_align
//  Description : Funnel shifter for the fetch byte queue. Shifts storage down
//                by the consumed byte count, then overlays the usable part of
//                an incoming line starting at byte position ins_base_i.
//  Ports       : storage_i  current storage, byte 0 = oldest
//                shift_i    bytes consumed this cycle
//                ins_en_i   a line is appended this cycle
//                ins_base_i first storage byte written by the line
//                ins_skip_i leading line bytes to drop (0..16)
//                line_i     incoming line, byte 0 in [7:0]
//                storage_o  next storage contents
//  Revision    : 1.0 - initial release
// ============================================================================
module fbq_byte_align
    import fetch_pkg::*;
#(
    parameter int QBYTES = QBYTES_DEF
) (
    input  wire logic [QBYTES*8-1:0] storage_i,
    input  wire bcnt_t               shift_i,
    input  wire logic                ins_en_i,
    input  wire bcnt_t               ins_base_i,
    input  wire logic [4:0]          ins_skip_i,
    input  wire logic [127:0]        line_i,
    output logic      [QBYTES*8-1:0] storage_o
);

    logic [QBYTES*8-1:0] w_shifted;
    logic [127:0]        w_line_sh;
    bcnt_t               w_ins_len;
    bcnt_t               w_rel;

    always_comb begin
        w_shifted = storage_i >> {shift_i, 3'b000};
        w_line_sh = line_i >> {ins_skip_i, 3'b000};
        w_ins_len = bcnt_t'(LINE_BYTES) - {1'b0, ins_skip_i};
        w_rel     = '0;
        storage_o = w_shifted;
        for (int i = 0; i < QBYTES; i++) begin
            // Position of this storage byte relative to the insertion point;
            // only meaningful when i >= ins_base_i.
            w_rel = bcnt_t'(i) - ins_base_i;
            if (ins_en_i && (bcnt_t'(i) >= ins_base_i) && (w_rel < w_ins_len)) begin
                storage_o[i*8 +: 8] = w_line_sh[{w_rel[3:0], 3'b000} +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_byte_queue
//  Description : Byte FIFO between the I-cache and the decoder. Accepts
//                16-byte lines, drops the leading bytes of the first line
//                after a redirect, and hands decode a 16-byte window of the
//                oldest bytes together with their address.
//  Ports       : clk, reset     clock, asynchronous active-high reset
//                flush*         redirect (target, taken-branch origin)
//                halt           freeze fetch and decode handoff
//                bus (master)   I-cache request/line and decode handshakes
//  Option      : FETCH_BYTE_QUEUE_BYPASS_EN - when defined, a line accepted
//                into an empty queue is shown to decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int                IADDRW   = IADDRW_DEF,
    parameter int                QBYTES   = QBYTES_DEF,
    parameter logic [IADDRW-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              flush,
    input  wire logic [IADDRW-1:0] flush_pc,
    input  wire logic              flush_taken,
    input  wire logic              halt,
    fetch_byte_queue_if.master     bus
);

    bcnt_t               count_q,  count_d;
    logic [IADDRW-1:0]   pc_q,     pc_d;
    logic [IADDRW-1:0]   icaddr_q, icaddr_d;
    logic [3:0]          skip_q,   skip_d;
    logic                taken_q,  taken_d;
    logic [QBYTES*8-1:0] store_q,  store_d;

    logic [QBYTES*8-1:0] w_aligned;
    logic [127:0]        w_line_sh;
    bcnt_t               w_vb;
    bcnt_t               w_cons;
    bcnt_t               w_fill_len;
    bcnt_t               w_ins_base;
    logic [4:0]          w_ins_skip;
    logic                w_fill;
    logic                w_consume;
    logic                w_bypass;

    assign bus.ic_ready = !flush && !halt
                        && (count_q <= bcnt_t'(QBYTES - LINE_BYTES));
    assign w_fill       = bus.ic_valid && bus.ic_ready;

`ifdef FETCH_BYTE_QUEUE_BYPASS_EN
    assign w_bypass = w_fill && (count_q == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // The incoming line with the redirect offset already dropped; this is
    // what decode sees when an empty queue is bypassed.
    assign w_line_sh  = bus.ic_line >> {skip_q, 3'b000};
    assign w_fill_len = bcnt_t'(LINE_BYTES) - {2'b00, skip_q};

    assign w_vb               = w_bypass ? w_fill_len : clamp16(count_q);
    assign bus.f_valid        = w_bypass || ((count_q != '0) && !halt);
    assign bus.f_valid_bytes  = w_vb;
    assign bus.f_instruction  = w_bypass ? w_line_sh : store_q[LINE_BYTES*8-1:0];
    assign bus.f_pc           = pc_q;
    assign bus.f_branch_taken = taken_q;
    assign bus.ic_addr        = icaddr_q;

    // A redirect discards any same-cycle consume; an over-long read is
    // clamped to what is actually presented.
    assign w_consume = bus.f_valid && bus.f_ready && !flush;
    assign w_cons    = !w_consume                 ? '0   :
                       (bus.f_bytes_read > w_vb)  ? w_vb : bus.f_bytes_read;

    // In the bypass case the consumed bytes come straight out of the line,
    // so they are dropped on insertion rather than shifted out of storage.
    assign w_ins_base = w_bypass ? '0 : (count_q - w_cons);
    assign w_ins_skip = w_bypass ? ({1'b0, skip_q} + w_cons[4:0]) : {1'b0, skip_q};

    fbq_byte_align #(
        .QBYTES (QBYTES)
    ) u_align (
        .storage_i  (store_q),
        .shift_i    (w_bypass ? bcnt_t'(0) : w_cons),
        .ins_en_i   (w_fill),
        .ins_base_i (w_ins_base),
        .ins_skip_i (w_ins_skip),
        .line_i     (bus.ic_line),
        .storage_o  (w_aligned)
    );

    always_comb begin
        count_d  = count_q;
        pc_d     = pc_q;
        icaddr_d = icaddr_q;
        skip_d   = skip_q;
        taken_d  = taken_q;
        store_d  = store_q;
        if (flush) begin
            count_d  = '0;
            pc_d     = flush_pc;
            icaddr_d = {flush_pc[IADDRW-1:4], 4'b0000};
            skip_d   = flush_pc[3:0];
            taken_d  = flush_taken;
        end else begin
            count_d = count_q - w_cons + (w_fill ? w_fill_len : bcnt_t'(0));
            pc_d    = pc_q + IADDRW'(w_cons);
            store_d = w_aligned;
            if (w_fill) begin
                icaddr_d = icaddr_q + IADDRW'(LINE_BYTES);
                skip_d   = 4'h0;
            end
            if (w_consume) begin
                taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            pc_q     <= RESET_PC;
            icaddr_q <= {RESET_PC[IADDRW-1:4], 4'b0000};
            skip_q   <= RESET_PC[3:0];
            taken_q  <= 1'b0;
            store_q  <= '0;
        end else begin
            count_q  <= count_d;
            pc_q     <= pc_d;
            icaddr_q <= icaddr_d;
            skip_q   <= skip_d;
            taken_q  <= taken_d;
            store_q  <= store_d;
        end
    end

endmodule
`default_nettype wire
